// File: rtl/div.sv
// div -- multi-cycle restoring divider for the EX stage (DIV / DIVU).
//
// One quotient bit is produced per clock. Operands are captured as magnitudes
// on start, the unsigned restoring loop runs DATA_W steps, and the signs are
// applied on the final step. EX holds start_i until ready_o is seen, and
// stalls the pipeline while start_i=1 and ready_o=0.
//
// Ports:
//   clk           pipeline clock, rising edge
//   rst           asynchronous active-low reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held until ready_o
//   annul_i       flush/exception abort (ignored once the result is ready)
//   result_o      {remainder, quotient}
//   ready_o       result valid
module div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'b00,
        S_BYZERO = 2'b01,
        S_ON     = 2'b10,
        S_END    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t                r_state, w_state_nx;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
    // {partial remainder, dividend/quotient}: dividend bits shift out the top
    // while quotient bits shift in at the bottom.
    logic [2*DATA_W-1:0]   r_acc, w_acc_nx;
    logic [DATA_W-1:0]     r_divisor, w_divisor_nx;
    logic                  r_qneg, w_qneg_nx;
    logic                  r_rneg, w_rneg_nx;
    logic [2*DATA_W-1:0]   r_result, w_result_nx;
    logic                  r_ready, w_ready_nx;

    // Operand magnitudes. Negating the most negative value yields the same
    // bit pattern, which is the correct unsigned magnitude.
    logic                  w_sign1, w_sign2;
    logic [DATA_W-1:0]     w_abs1, w_abs2;

    assign w_sign1 = signed_div_i & opdata1_i[DATA_W-1];
    assign w_sign2 = signed_div_i & opdata2_i[DATA_W-1];
    assign w_abs1  = w_sign1 ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_abs2  = w_sign2 ? (~opdata2_i + 1'b1) : opdata2_i;

    // One restoring step. The shifted partial remainder needs DATA_W+1 bits;
    // after a successful subtract it is below the divisor and fits DATA_W.
    logic [DATA_W:0]       w_top;
    logic                  w_take;
    logic [DATA_W-1:0]     w_diff;
    logic [2*DATA_W-1:0]   w_step;
    logic [DATA_W-1:0]     w_quo, w_rem, w_quo_s, w_rem_s;

    assign w_top   = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_take  = (w_top >= {1'b0, r_divisor});
    assign w_diff  = w_top[DATA_W-1:0] - r_divisor;
    assign w_step  = w_take ? {w_diff, r_acc[DATA_W-2:0], 1'b1}
                            : {r_acc[2*DATA_W-2:0], 1'b0};
    assign w_quo   = w_step[DATA_W-1:0];
    assign w_rem   = w_step[2*DATA_W-1:DATA_W];
    assign w_quo_s = r_qneg ? (~w_quo + 1'b1) : w_quo;
    assign w_rem_s = r_rneg ? (~w_rem + 1'b1) : w_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FREE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_divisor <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_acc     <= w_acc_nx;
            r_divisor <= w_divisor_nx;
            r_qneg    <= w_qneg_nx;
            r_rneg    <= w_rneg_nx;
            r_result  <= w_result_nx;
            r_ready   <= w_ready_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_acc_nx     = r_acc;
        w_divisor_nx = r_divisor;
        w_qneg_nx    = r_qneg;
        w_rneg_nx    = r_rneg;
        w_result_nx  = r_result;
        w_ready_nx   = r_ready;
        case (r_state)
            S_FREE: begin
                w_ready_nx  = 1'b0;
                w_result_nx = '0;
                if (start_i && !annul_i) begin
                    w_acc_nx     = {{DATA_W{1'b0}}, w_abs1};
                    w_divisor_nx = w_abs2;
                    w_qneg_nx    = w_sign1 ^ w_sign2;
                    w_rneg_nx    = w_sign1;
                    w_cnt_nx     = '0;
                    w_state_nx   = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                if (annul_i) begin
                    w_state_nx  = S_FREE;
                    w_ready_nx  = 1'b0;
                    w_result_nx = '0;
                    w_cnt_nx    = '0;
                end else begin
                    w_state_nx  = S_END;
                    w_ready_nx  = 1'b1;
                    w_result_nx = '0;
                end
            end
            S_ON: begin
                // Abort wins even over the completing step.
                if (annul_i) begin
                    w_state_nx  = S_FREE;
                    w_ready_nx  = 1'b0;
                    w_result_nx = '0;
                    w_cnt_nx    = '0;
                end else begin
                    w_acc_nx = w_step;
                    w_cnt_nx = r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_state_nx  = S_END;
                        w_ready_nx  = 1'b1;
                        w_result_nx = {w_rem_s, w_quo_s};
                    end
                end
            end
            S_END: begin
                if (!start_i) begin
                    w_state_nx  = S_FREE;
                    w_ready_nx  = 1'b0;
                    w_result_nx = '0;
                end
            end
            default: w_state_nx = S_FREE;
        endcase
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle restoring divider in the EX stage, one quotient bit per cycle.
- Directly upstream of the pipeline stall controller: EX raises its stall request while `start_i` is high and `ready_o` is low.
- That freezes PC/IF/ID/EX until the result returns.
- Serves DIV/DIVU; the result is written to HI (remainder) and LO (quotient).

Parameters:
- DATA_W, 32, operand width. Result is 2*DATA_W.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low: rst=0 clears all state immediately.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  request. Held high by EX until ready_o is seen.
- annul_i  in  1  flush/exception abort.
- result_o  out  2*DATA_W  {remainder, quotient}.
- ready_o  out  1  result valid.

Behaviour:
- Reset (rst=0, async): state=FREE, cnt=0, result_o=0, ready_o=0, internal dividend/divisor regs=0.
- States: FREE, BYZERO, ON, END, in a 2-bit registered encoding.
- FREE:
  - ready_o=0, result_o=0.
  - On an edge with start_i=1 and annul_i=0, latch |opdata1_i| and |opdata2_i|. Take magnitudes only if signed_div_i=1 and the operand MSB=1; otherwise use raw values.
  - Also latch the sign flags: qneg = sign1^sign2, rneg = sign1, both 0 when unsigned.
  - If opdata2_i==0, go to BYZERO; else go to ON with cnt=0.
- ON (annul_i=0):
  - Each edge performs one restoring step. Shift the {partial remainder, dividend} register left by 1 and trial-subtract the divisor from the upper DATA_W+1 bits.
  - If the trial result is non-negative, keep it and set quotient LSB=1; else set the bit to 0. Then cnt++.
  - On the edge where cnt==DATA_W-1, the final step completes. Apply signs (negate quotient if qneg, negate remainder if rneg), register result_o, set ready_o=1, go to END.
  - Latency: start sampled at edge k gives ready_o=1 after edge k+DATA_W (k+32 by default).
- BYZERO: on the next edge go to END with result_o=0, ready_o=1. Latency is k+1.
- annul_i=1 in ON or BYZERO: next edge goes to FREE with ready_o=0, result_o=0, cnt=0. annul_i has priority over step completion.
- END:
  - ready_o=1 and result_o stable while start_i=1.
  - On an edge with start_i=0, go to FREE with ready_o=0, result_o=0.
  - annul_i is ignored in END.
- start_i deasserted during ON/BYZERO without annul_i: the operation completes normally; the result is presented in END for one cycle then cleared on the next edge.
- Operands are captured at start. Later changes on opdata*_i have no effect until the next FREE→start.
- Arithmetic:
  - Truncating division: quotient rounds toward zero; remainder has the dividend's sign.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps), remainder 0.
  - Unsigned ops never negate.
- Back-to-back: a new operation can start only from FREE. Minimum spacing is one idle (FREE) cycle after END.
- Reset asserted mid-operation aborts immediately. After release the block is in FREE and needs a fresh start_i.

Test Plan:
- Unsigned 100/7: start at edge k, unsigned → ready_o=0 through edge k+31, ready_o=1 after edge k+32, result_o={0x00000002, 0x0000000E}.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) → result_o={0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/-2 → {0x00000001, 0xFFFFFFFD}.
- Divide by zero 5/0 → ready_o=1 after edge k+1, result_o=0. Dropping start_i → FREE, ready_o=0 next edge.
- annul_i pulsed at cnt=10 → FREE next edge, ready_o never rises. A following start of 9/3 gives {0, 3} at k'+32.
- Signed 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000}. Unsigned same operands → {0x80000000, 0x00000000}.
- rst pulled low asynchronously mid-ON (between edges) → ready_o=0, result_o=0 immediately. Holding start_i=1 through END keeps ready_o=1 and result_o stable for 5 cycles.
